lmul_uop_sequencer: RTL

- Sits between vector decode and the vector ALU/regfile read stage. It sequences one RVV instruction with register grouping into LMUL single-register micro-ops.
- Each micro-op's source and destination register specifiers advance by 1 per micro-op.
- It holds the front end (IF1/IF2) stalled while a group is in flight.
- This is the registered, handshaked replacement for the combinational stall-feedback loop in the current grouping path.

---
 rtl/lmul_uop_sequencer_pkg.sv | 55 +++++
 rtl/lmul_uop_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/lmul_uop_sequencer_pkg.sv
// rvv_lmul_pkg: shared definitions for vector register grouping.
// Holds the vlmul encodings, the encoding-to-uop-count decode, the group
// alignment check and the sequencer state type. The decode function is also
// used by the vtype/CSR logic, so it stays free of module parameters: the
// count for the reserved encoding is passed in by the caller.
package rvv_lmul_pkg;

  localparam logic [2:0] VLMUL_M1   = 3'b000;
  localparam logic [2:0] VLMUL_M2   = 3'b001;
  localparam logic [2:0] VLMUL_M4   = 3'b010;
  localparam logic [2:0] VLMUL_M8   = 3'b011;
  localparam logic [2:0] VLMUL_RSVD = 3'b100;
  localparam logic [2:0] VLMUL_MF8  = 3'b101;
  localparam logic [2:0] VLMUL_MF4  = 3'b110;
  localparam logic [2:0] VLMUL_MF2  = 3'b111;

  // Wide enough to hold a count of 8.
  localparam int unsigned LMUL_CNT_W = 4;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } seq_state_e;

  // Number of single-register micro-ops for an encoded vlmul.
  // Fractional groups still occupy one register.
  function automatic logic [LMUL_CNT_W-1:0] lmul_decode(
    input logic [2:0]            enc,
    input logic [LMUL_CNT_W-1:0] max_lmul
  );
    logic [LMUL_CNT_W-1:0] cnt;
    case (enc)
      VLMUL_M1:   cnt = 4'd1;
      VLMUL_M2:   cnt = 4'd2;
      VLMUL_M4:   cnt = 4'd4;
      VLMUL_M8:   cnt = 4'd8;
      VLMUL_RSVD: cnt = max_lmul;
      default:    cnt = 4'd1;
    endcase
    return cnt;
  endfunction

  // A group of cnt registers must start on a multiple of cnt. low_or is the
  // OR of the low three bits of every specifier in the group, so a single
  // mask test covers all of them at once.
  function automatic logic lmul_aligned(
    input logic [LMUL_CNT_W-1:0] cnt,
    input logic [2:0]            low_or
  );
    logic [LMUL_CNT_W-1:0] mask;
    mask = cnt - 4'd1;
    return (low_or & mask[2:0]) == 3'b000;
  endfunction

endpackage

// File: rtl/lmul_uop_sequencer.sv
// lmul_uop_sequencer: splits one grouped RVV instruction into LMUL
// single-register micro-ops, with the register specifiers advancing by one
// per micro-op, and holds IF1/IF2 stalled while a group is in flight.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid / in_ready        decoded instruction handshake
//   raA, raB, rdest            base specifiers of the group
//   lmul_reg                   encoded vlmul from vtype
//   flush                      discard the in-flight group
//   out_valid / out_ready      micro-op handshake
//   raA_out, raB_out, rdest_out  micro-op specifiers (registered)
//   uop_idx, uop_last          position of the micro-op within its group
//   fe_stall                   stall request to the front end
//   illegal                    one-cycle pulse for a rejected misaligned group
module lmul_uop_sequencer
  import rvv_lmul_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MAX_LMUL   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] raA,
  input  logic [REG_ADDR_W-1:0] raB,
  input  logic [REG_ADDR_W-1:0] rdest,
  input  logic [2:0]            lmul_reg,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] raA_out,
  output logic [REG_ADDR_W-1:0] raB_out,
  output logic [REG_ADDR_W-1:0] rdest_out,
  output logic [2:0]            uop_idx,
  output logic                  uop_last,
  output logic                  fe_stall,
  output logic                  illegal
);

  seq_state_e state_q, state_d;

  logic [REG_ADDR_W-1:0] base_a_q, base_b_q, base_d_q;
  logic [REG_ADDR_W-1:0] base_a_d, base_b_d, base_d_d;
  logic [LMUL_CNT_W-1:0] cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] raA_d, raB_d, rdest_d;
  logic [2:0]            idx_d;
  logic                  last_d;
  logic                  illegal_d;

  logic                  hs;
  logic                  accept;
  logic [LMUL_CNT_W-1:0] dec_cnt;
  logic                  dec_ok;
  logic [2:0]            idx_inc;

  always_comb begin
    out_valid = (state_q == ST_ISSUE);
    hs        = out_valid && out_ready;
    // Ready also in the cycle the last uop leaves, so a waiting instruction
    // loads without a bubble.
    in_ready  = !flush && ((state_q == ST_IDLE) || (hs && uop_last));
    fe_stall  = (state_q == ST_ISSUE) && !(out_ready && uop_last);
    accept    = in_valid && in_ready;

    dec_cnt = lmul_decode(lmul_reg, LMUL_CNT_W'(MAX_LMUL));
    dec_ok  = lmul_aligned(dec_cnt, raA[2:0] | raB[2:0] | rdest[2:0]);
    idx_inc = uop_idx + 3'd1;

    state_d   = state_q;
    base_a_d  = base_a_q;
    base_b_d  = base_b_q;
    base_d_d  = base_d_q;
    cnt_d     = cnt_q;
    raA_d     = raA_out;
    raB_d     = raB_out;
    rdest_d   = rdest_out;
    idx_d     = uop_idx;
    last_d    = uop_last;
    illegal_d = 1'b0;

    if (flush) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      last_d  = 1'b0;
    end else if (accept) begin
      base_a_d = raA;
      base_b_d = raB;
      base_d_d = rdest;
      cnt_d    = dec_cnt;
      idx_d    = '0;
      if (dec_ok) begin
        state_d = ST_ISSUE;
        raA_d   = raA;
        raB_d   = raB;
        rdest_d = rdest;
        last_d  = (dec_cnt == 4'd1);
      end else begin
        state_d   = ST_IDLE;
        last_d    = 1'b0;
        illegal_d = 1'b1;
      end
    end else if (hs) begin
      if (uop_last) begin
        state_d = ST_IDLE;
        idx_d   = '0;
        last_d  = 1'b0;
      end else begin
        // Specifiers are precomputed for the next index so the outputs
        // come straight from flops.
        idx_d   = idx_inc;
        raA_d   = base_a_q + REG_ADDR_W'(idx_inc);
        raB_d   = base_b_q + REG_ADDR_W'(idx_inc);
        rdest_d = base_d_q + REG_ADDR_W'(idx_inc);
        last_d  = ({1'b0, idx_inc} == (cnt_q - 4'd1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      base_a_q  <= '0;
      base_b_q  <= '0;
      base_d_q  <= '0;
      cnt_q     <= '0;
      raA_out   <= '0;
      raB_out   <= '0;
      rdest_out <= '0;
      uop_idx   <= '0;
      uop_last  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_a_q  <= base_a_d;
      base_b_q  <= base_b_d;
      base_d_q  <= base_d_d;
      cnt_q     <= cnt_d;
      raA_out   <= raA_d;
      raB_out   <= raB_d;
      rdest_out <= rdest_d;
      uop_idx   <= idx_d;
      uop_last  <= last_d;
      illegal   <= illegal_d;
    end
  end

endmodule
